serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit, a one-cycle request to begin an addition.
REQ-005 The module SHALL have port a, input, WIDTH bits, operand A, sampled only when start is accepted.
REQ-006 The module SHALL have port b, input, WIDTH bits, operand B, sampled only when start is accepted.
REQ-007 The module SHALL have port cin, input, 1 bit, carry-in, sampled only when start is accepted.
REQ-008 The module SHALL have port busy, output, 1 bit, high while bits are being shifted.
REQ-009 The module SHALL have port done, output, 1 bit, a one-cycle pulse when the result becomes valid.
REQ-010 The module SHALL have port sum, output, WIDTH bits, the registered result of a+b+cin modulo 2^WIDTH.
REQ-011 The module SHALL have port cout, output, 1 bit, the registered carry-out of the most significant bit.

Function
REQ-012 The datapath SHALL use exactly one 1-bit full_adder instance (ports a, b, cin, sum, cout), time-multiplexed LSB-first.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE, with IDLE entered on reset.
REQ-014 In IDLE with start=1 at edge T, the block SHALL load a, b and cin into internal shift and carry registers, clear the bit counter and go to SHIFT.
REQ-015 At each SHIFT edge, the block SHALL feed operand LSBs plus the carry register to the full_adder, shift its sum bit into the result register from the MSB side, store its cout in the carry register, shift both operands right and increment the counter.
REQ-016 After the WIDTH-th shift (edge T+WIDTH), the block SHALL copy the result register to sum and the carry to cout, then go to DONE.
REQ-017 busy SHALL be 1 exactly while in SHIFT, i.e. for the WIDTH cycles following edge T.
REQ-018 done SHALL be 1 exactly while in DONE, i.e. for one cycle after edge T+WIDTH; DONE SHALL return to IDLE unconditionally on the next edge.
REQ-019 Total latency SHALL be WIDTH+1 cycles from the start edge to the done cycle.
REQ-020 start SHALL be ignored in SHIFT and in DONE, with no effect on operands, counter or outputs.
REQ-021 sum and cout SHALL change only at the completion edge (REQ-016) and SHALL hold their values through IDLE and any subsequent SHIFT until the next completion.
REQ-022 The counter SHALL be $clog2(WIDTH)+1 bits wide, and no counter value SHALL wrap during SHIFT.
REQ-023 start may be reasserted in the first IDLE cycle after DONE, giving a minimum issue interval of WIDTH+2 cycles.

Reset
REQ-024 With rst=1 at an edge, the block SHALL set state to IDLE and busy, done, sum, cout, the counter, the carry register and the shift registers to 0.
REQ-025 rst SHALL take priority over start and over any in-progress SHIFT; an interrupted addition SHALL be discarded with no done pulse.
REQ-026 When rst and start are both high at the same edge, the block SHALL reset and SHALL NOT accept the start.

Verification
REQ-027 For WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> 9 cycles later done=1, sum=8'h00, cout=1.
REQ-028 For WIDTH=8, a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; then a=8'hA5, b=8'h5A, cin=0 -> sum=8'hFF, cout=0.
REQ-029 For WIDTH=8, a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1; busy is high for exactly 8 cycles and done for exactly 1 cycle.
REQ-030 For WIDTH=8: start with a=8'h03, b=8'h04, then start pulsed with a=8'hF0 on the 3rd busy cycle -> result is sum=8'h07, cout=0, and sum holds its prior value until completion.
REQ-031 For WIDTH=8: rst=1 on the 4th busy cycle -> next cycle busy=0, done=0, sum=8'h00, cout=0, and no done pulse follows.
REQ-032 For WIDTH=2: all 32 combinations of a, b and cin, issued at the minimum interval -> {cout,sum} == a+b+cin for every combination.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder built around one time-multiplexed full adder
//
// full_adder  : combinational 1-bit adder (a, b, cin -> sum, cout)
// serial_adder: WIDTH-bit adder, one bit per clock, LSB first
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   start in   one-cycle request; a, b, cin captured only when accepted in IDLE
//   a, b  in   WIDTH-bit operands
//   cin   in   carry-in
//   busy  out  high while bits are being shifted (WIDTH cycles)
//   done  out  one-cycle pulse when sum/cout become valid
//   sum   out  registered (a+b+cin) mod 2^WIDTH, held until the next completion
//   cout  out  registered carry-out of the MSB

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // One extra bit beyond $clog2 so the counter never wraps, even at WIDTH = 2^n.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // The shift in progress is the final (MSB) one.
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                    res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
                    carry  <= fa_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        sum  <= {fa_sum, res_sh[WIDTH-1:1]};
                        cout <= fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=2)

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;
    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       cin2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Runs ncyc negedges after a start edge; optionally re-pulses start with a=inj_a at inject_at.
    task automatic observe8(input int ncyc, input int inject_at, input logic [7:0] inj_a,
                            input logic [7:0] prev, output int busy_n, output int done_n,
                            output int done_at, output logic [7:0] rs, output logic rc,
                            output int held_bad);
        busy_n = 0; done_n = 0; done_at = 0; rs = '0; rc = 1'b0; held_bad = 0;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (busy8) begin
                busy_n++;
                if (sum8 !== prev) held_bad++;
            end
            if (done8) begin
                done_n++;
                done_at = i;
                rs = sum8;
                rc = cout8;
            end
            if (i == inject_at) begin
                start8 = 1'b1;
                a8 = inj_a;
            end else begin
                start8 = 1'b0;
            end
        end
    endtask

    vec_t       vecs[8];
    logic [7:0] prev;
    int         bn, dn, dat, hb;
    logic [7:0] rs;
    logic       rc;
    logic [2:0] exp2;

    initial begin
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

        rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        chk("reset_sum",  32'(sum8),  32'd0);
        chk("reset_cout", 32'(cout8), 32'd0);

        prev = 8'h00;
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            a8 = vecs[v].a; b8 = vecs[v].b; cin8 = vecs[v].cin; start8 = 1'b1;
            observe8(11, 0, 8'h00, prev, bn, dn, dat, rs, rc, hb);
            chk($sformatf("vec%0d_sum", v),     32'(rs),  32'(vecs[v].exp_sum));
            chk($sformatf("vec%0d_cout", v),    32'(rc),  32'(vecs[v].exp_cout));
            chk($sformatf("vec%0d_busy_n", v),  32'(bn),  32'd8);
            chk($sformatf("vec%0d_done_n", v),  32'(dn),  32'd1);
            chk($sformatf("vec%0d_latency", v), 32'(dat), 32'd9);
            chk($sformatf("vec%0d_sum_held", v), 32'(hb), 32'd0);
            prev = vecs[v].exp_sum;
        end

        // start re-pulsed with a different operand on the 3rd busy cycle is ignored
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
        observe8(11, 3, 8'hF0, prev, bn, dn, dat, rs, rc, hb);
        chk("ignore_start_sum",  32'(rs), 32'h07);
        chk("ignore_start_cout", 32'(rc), 32'd0);
        chk("ignore_start_held", 32'(hb), 32'd0);
        chk("ignore_start_done", 32'(dn), 32'd1);
        prev = 8'h07;

        // reset on the 4th busy cycle aborts the addition
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        observe8(4, 0, 8'h00, prev, bn, dn, dat, rs, rc, hb);
        chk("abort_pre_busy_n", 32'(bn), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_sum",  32'(sum8),  32'd0);
        chk("abort_cout", 32'(cout8), 32'd0);
        observe8(12, 0, 8'h00, 8'h00, bn, dn, dat, rs, rc, hb);
        chk("abort_no_done", 32'(dn), 32'd0);

        // rst and start together: start is not accepted
        @(negedge clk);
        rst = 1'b1; a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        observe8(12, 0, 8'h00, 8'h00, bn, dn, dat, rs, rc, hb);
        chk("rst_start_busy_n", 32'(bn), 32'd0);
        chk("rst_start_done_n", 32'(dn), 32'd0);

        // WIDTH=2 exhaustive at the minimum issue interval of 4 cycles
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            {a2, b2, cin2} = i[4:0];
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            @(negedge clk);
            @(negedge clk);
            exp2 = 3'(a2) + 3'(b2) + 3'(cin2);
            chk($sformatf("w2_done_%0d", i), 32'(done2), 32'd1);
            chk($sformatf("w2_result_%0d", i), 32'({cout2, sum2}), 32'(exp2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
